mac_acc_matmul: RTL and testbench
=================================

Name: mac_acc_matmul

Overview:
- Parameterised successor to the single-product MAC/stop multiplier.
- Computes a full C = A x B, with A of size MxK and B of size KxN, and writes each accumulated C element to a result memory.
- Sits between two read-only operand memories (A, B) and a write-only result memory (C), under control of a level-sensitive do_mac from the top-level controller.
- Adds over the previous generation: K-deep accumulation, result write-back, a signed/unsigned mode and a defined pause/stop behaviour.

Parameters:
M, 4, rows of A and C (>=2)
N, 4, columns of B and C (>=2)
K, 4, inner dimension (>=2)
DATA_WIDTH_INIT_MATRIX, 32, operand width W
DATA_WIDTH_RESULT_MATRIX, 2*W+$clog2(K), accumulator/result width R
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
do_mac  in  1  run enable (level); low pauses or stops the block
data_in_a  in  W  A memory read data, valid the cycle after matrix_a_re
data_in_b  in  W  B memory read data, valid the cycle after matrix_b_re
row_addr_a  out  $clog2(M)  A row address
col_addr_a  out  $clog2(K)  A column address
row_addr_b  out  $clog2(K)  B row address
col_addr_b  out  $clog2(N)  B column address
matrix_a_re  out  1  A read enable
matrix_b_re  out  1  B read enable
product_reg  out  2W  last registered product a*b
mult_done_reg  out  1  one-cycle pulse when product_reg updates
acc_reg  out  R  running accumulator
row_addr_c  out  $clog2(M)  C row address
col_addr_c  out  $clog2(N)  C column address
data_out_c  out  R  C write data
matrix_c_we  out  1  C write enable, one-cycle pulse
mac_done  out  1  whole matrix complete

Behaviour:
- Reset: all outputs, counters, registers and the accumulator go to 0; FSM goes to IDLE.
  - Reset asserted mid-operation aborts the matrix; no write is issued in the reset cycle.
- Counters:
  - i (row of A, row of C): 0..M-1.
  - j (column of B, column of C): 0..N-1.
  - k (inner index): 0..K-1.
  - Address mapping: row_addr_a = i, col_addr_a = k, row_addr_b = k, col_addr_b = j, row_addr_c = i, col_addr_c = j.
- FSM states:
  - IDLE: all outputs inactive. Goes to READ when do_mac=1; i, j, k and acc are cleared on entry to READ.
  - READ:
    - If do_mac=1: assert matrix_a_re and matrix_b_re for exactly 1 cycle, then go to CAPT.
    - If do_mac=0: hold in READ with both read enables low. This is the only pause point; in-flight CAPT/MULT/ACC/WRITE always complete.
  - CAPT: latch data_in_a and data_in_b into internal operand registers; go to MULT.
  - MULT:
    - product_reg <= a*b, signed or unsigned per SIGNED, full 2W width.
    - mult_done_reg=1 for this cycle only; go to ACC.
  - ACC:
    - acc <= acc + product_reg, with the product sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to R bits.
    - If k==K-1: go to WRITE. Otherwise k++ and go to READ.
  - WRITE:
    - matrix_c_we=1 and data_out_c=acc for 1 cycle; then acc<=0 and k<=0.
    - Advance j; on wrap (j==N-1 -> 0) advance i.
    - If i==M-1 and j==N-1: go to DONE, otherwise go to READ.
  - DONE:
    - mac_done=1 and held.
    - When do_mac falls, go to IDLE and mac_done falls the next cycle.
    - A new run requires do_mac low then high.
- Latency:
  - 4 cycles per k-step plus 1 write cycle per element.
  - Total from first READ to DONE (no pauses) = M*N*(4K+1) cycles: 272 at 4x4x4.
- Width: R is sized so that K maximum-magnitude products cannot overflow; no saturation logic is required.
- Address outputs are driven continuously from the counters and are only meaningful when the associated re/we is high.

Decomposition:
- Shared package mac_pkg:
  - FSM state enum (IDLE, READ, CAPT, MULT, ACC, WRITE, DONE).
  - Helper functions for result width and counter widths.
- One sub-module, mac_mult_unit: registered signed/unsigned W x W multiplier with a valid pulse (provides product_reg and mult_done_reg).
- All counters and the FSM stay in the top module.

Test Plan:
1. Unsigned 4x4x4: A={{6,2,5,2},{6,2,6,1},{2,4,5,2},{7,2,5,1}}, B={{1,1,4,4},{1,7,2,1},{3,2,1,1},{2,1,6,6}}, do_mac held high -> C[0][0]=27, C[3][3]=41, all 16 C writes correct; mac_done rises at cycle 272 after the first READ.
2. Product check: on every mult_done_reg pulse, product_reg equals the A/B operands fetched by the preceding re -> first pulse shows 6*1=6.
3. Pause: drop do_mac for 10 cycles during the second READ of element (1,2) -> no re while low; results identical to scenario 1; completion delayed by exactly 10 cycles.
4. Signed mode: SIGNED=1, W=8, A all -3, B all 2 -> every C element = -24, sign-extended to R=18 bits (0x3FFE8).
5. Width corner: SIGNED=0, W=8, A and B all 255 -> every C element = 260100 with no overflow.
6. Reset mid-run: assert reset for 1 cycle during ACC of element (2,1) -> all outputs 0 and FSM in IDLE; a fresh do_mac then produces the full correct C from (0,0).

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and width helpers for the matrix MAC block.
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        CAPT,
        MULT,
        ACC,
        WRITE,
        DONE
    } mac_state_e;

    // K full-width products fit without overflow in 2W + clog2(K) bits.
    function automatic int res_width(input int w, input int k);
        return 2 * w + $clog2(k);
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_mult_unit.sv
// Registered W x W multiplier, signed or unsigned, with a one-cycle valid pulse.
module mac_mult_unit #(
    parameter int W      = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   product,
    output logic             done
);

    logic [2*W-1:0] ext_a;
    logic [2*W-1:0] ext_b;

    // Extending both operands to 2W makes the low 2W bits of the product
    // correct for two's-complement and unsigned alike.
    assign ext_a = {{W{SIGNED & a[W-1]}}, a};
    assign ext_b = {{W{SIGNED & b[W-1]}}, b};

    always_ff @(posedge clk) begin
        if (reset) begin
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= start;
            if (start) begin
                product <= ext_a * ext_b;
            end
        end
    end

endmodule

// File: rtl/mac_acc_matmul.sv
// C = A x B engine: fetches operand pairs, multiplies, accumulates K deep and writes each C element.
module mac_acc_matmul
    import mac_pkg::*;
#(
    parameter int M                        = 4,
    parameter int N                        = 4,
    parameter int K                        = 4,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = res_width(DATA_WIDTH_INIT_MATRIX, K),
    parameter bit SIGNED                   = 1'b0
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  do_mac,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_in_b,
    output logic [cnt_width(M)-1:0]               row_addr_a,
    output logic [cnt_width(K)-1:0]               col_addr_a,
    output logic [cnt_width(K)-1:0]               row_addr_b,
    output logic [cnt_width(N)-1:0]               col_addr_b,
    output logic                                  matrix_a_re,
    output logic                                  matrix_b_re,
    output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
    output logic                                  mult_done_reg,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]   acc_reg,
    output logic [cnt_width(M)-1:0]               row_addr_c,
    output logic [cnt_width(N)-1:0]               col_addr_c,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0]   data_out_c,
    output logic                                  matrix_c_we,
    output logic                                  mac_done
);

    localparam int W  = DATA_WIDTH_INIT_MATRIX;
    localparam int R  = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = cnt_width(M);
    localparam int NW = cnt_width(N);
    localparam int KW = cnt_width(K);

    localparam logic [MW-1:0] M_LAST = MW'(M - 1);
    localparam logic [NW-1:0] N_LAST = NW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);

    mac_state_e state, state_nxt;

    logic [MW-1:0] i_cnt;
    logic [NW-1:0] j_cnt;
    logic [KW-1:0] k_cnt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [R-1:0]  prod_ext;
    logic          prod_sgn;

    mac_mult_unit #(
        .W      (W),
        .SIGNED (SIGNED)
    ) u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (state == MULT),
        .a       (op_a),
        .b       (op_b),
        .product (product_reg),
        .done    (mult_done_reg)
    );

    assign prod_sgn = SIGNED & product_reg[2*W-1];
    assign prod_ext = {{(R - 2*W){prod_sgn}}, product_reg};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (do_mac) state_nxt = READ;
            READ:    if (do_mac) state_nxt = CAPT;
            CAPT:    state_nxt = MULT;
            MULT:    state_nxt = ACC;
            ACC:     state_nxt = (k_cnt == K_LAST) ? WRITE : READ;
            WRITE:   state_nxt = (i_cnt == M_LAST && j_cnt == N_LAST) ? DONE : READ;
            DONE:    if (!do_mac) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i_cnt   <= '0;
            j_cnt   <= '0;
            k_cnt   <= '0;
            acc_reg <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (do_mac) begin
                        i_cnt   <= '0;
                        j_cnt   <= '0;
                        k_cnt   <= '0;
                        acc_reg <= '0;
                    end
                end
                CAPT: begin
                    op_a <= data_in_a;
                    op_b <= data_in_b;
                end
                ACC: begin
                    acc_reg <= acc_reg + prod_ext;
                    if (k_cnt != K_LAST) k_cnt <= k_cnt + 1'b1;
                end
                WRITE: begin
                    acc_reg <= '0;
                    k_cnt   <= '0;
                    if (j_cnt == N_LAST) begin
                        j_cnt <= '0;
                        i_cnt <= (i_cnt == M_LAST) ? '0 : i_cnt + 1'b1;
                    end else begin
                        j_cnt <= j_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read enables follow do_mac combinationally so READ is the single pause point.
    assign matrix_a_re = (state == READ) && do_mac && !reset;
    assign matrix_b_re = matrix_a_re;
    assign matrix_c_we = (state == WRITE) && !reset;
    assign data_out_c  = matrix_c_we ? acc_reg : '0;
    assign mac_done    = (state == DONE);

    assign row_addr_a = i_cnt;
    assign col_addr_a = k_cnt;
    assign row_addr_b = k_cnt;
    assign col_addr_b = j_cnt;
    assign row_addr_c = i_cnt;
    assign col_addr_c = j_cnt;

endmodule

// File: tb/tb_mac_acc_matmul.sv
// Directed bench: 4x4x4 unsigned matmul with pause and mid-run reset, plus 8-bit signed and max-value runs.
module tb_mac_acc_matmul;

    localparam int W  = 32;
    localparam int R  = 66;
    localparam int R8 = 18;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic do_mac = 1'b0;
    logic do_mac2 = 1'b0;

    // main instance
    logic [W-1:0]   data_in_a, data_in_b;
    logic [1:0]     row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c;
    logic           matrix_a_re, matrix_b_re, mult_done_reg, matrix_c_we, mac_done;
    logic [2*W-1:0] product_reg;
    logic [R-1:0]   acc_reg, data_out_c;

    // signed 8-bit instance
    logic [7:0]     s_a = 8'hFD;
    logic [7:0]     s_b = 8'h02;
    logic [1:0]     s_ra, s_ca, s_rb, s_cb, s_rc, s_cc;
    logic           s_are, s_bre, s_mdone, s_we, s_done;
    logic [15:0]    s_prod;
    logic [R8-1:0]  s_acc, s_dout;

    // unsigned 8-bit max-value instance
    logic [7:0]     c_a = 8'hFF;
    logic [7:0]     c_b = 8'hFF;
    logic [1:0]     c_ra, c_ca, c_rb, c_cb, c_rc, c_cc;
    logic           c_are, c_bre, c_mdone, c_we, c_done;
    logic [15:0]    c_prod;
    logic [R8-1:0]  c_acc, c_dout;

    mac_acc_matmul u_dut (
        .clk(clk), .reset(reset), .do_mac(do_mac),
        .data_in_a(data_in_a), .data_in_b(data_in_b),
        .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
        .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re),
        .product_reg(product_reg), .mult_done_reg(mult_done_reg), .acc_reg(acc_reg),
        .row_addr_c(row_addr_c), .col_addr_c(col_addr_c), .data_out_c(data_out_c),
        .matrix_c_we(matrix_c_we), .mac_done(mac_done)
    );

    mac_acc_matmul #(.DATA_WIDTH_INIT_MATRIX(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .reset(reset), .do_mac(do_mac2),
        .data_in_a(s_a), .data_in_b(s_b),
        .row_addr_a(s_ra), .col_addr_a(s_ca), .row_addr_b(s_rb), .col_addr_b(s_cb),
        .matrix_a_re(s_are), .matrix_b_re(s_bre),
        .product_reg(s_prod), .mult_done_reg(s_mdone), .acc_reg(s_acc),
        .row_addr_c(s_rc), .col_addr_c(s_cc), .data_out_c(s_dout),
        .matrix_c_we(s_we), .mac_done(s_done)
    );

    mac_acc_matmul #(.DATA_WIDTH_INIT_MATRIX(8), .SIGNED(1'b0)) u_cor (
        .clk(clk), .reset(reset), .do_mac(do_mac2),
        .data_in_a(c_a), .data_in_b(c_b),
        .row_addr_a(c_ra), .col_addr_a(c_ca), .row_addr_b(c_rb), .col_addr_b(c_cb),
        .matrix_a_re(c_are), .matrix_b_re(c_bre),
        .product_reg(c_prod), .mult_done_reg(c_mdone), .acc_reg(c_acc),
        .row_addr_c(c_rc), .col_addr_c(c_cc), .data_out_c(c_dout),
        .matrix_c_we(c_we), .mac_done(c_done)
    );

    always #5 clk = ~clk;

    int a_m[4][4] = '{'{6,2,5,2}, '{6,2,6,1}, '{2,4,5,2}, '{7,2,5,1}};
    int b_m[4][4] = '{'{1,1,4,4}, '{1,7,2,1}, '{3,2,1,1}, '{2,1,6,6}};
    int c_exp[4][4] = '{'{27,32,45,43}, '{28,33,40,38}, '{25,42,33,29}, '{26,32,43,41}};

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr_cnt = 0;
    int          s_wr = 0;
    int          c_wr = 0;
    int          re_paused = 0;
    bit          paused = 1'b0;
    bit          first_seen = 1'b0;
    logic [63:0] pq[$];
    logic [R-1:0] c_got[4][4];

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_run();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) c_got[r][c] = '0;
        wr_cnt = 0;
        pq.delete();
    endtask

    // Runs one full matrix; optional 10-cycle do_mac drop after tick pause_at.
    task automatic run_main(input int pause_at, output int cycles);
        int n;
        n = 0;
        do_mac = 1'b1;
        do begin
            tick();
            n++;
            if (n == pause_at) begin
                do_mac = 1'b0;
                paused = 1'b1;
            end
            if (pause_at != 0 && n == pause_at + 10) begin
                do_mac = 1'b1;
                paused = 1'b0;
            end
        end while (!mac_done && n < 1000);
        cycles = n - 1;
        do_mac = 1'b0;
        tick();
        tick();
        chk("done_fall", {71'd0, mac_done}, 72'd0);
    endtask

    task automatic check_c(input string tag);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s_c%0d%0d", tag, r, c), c_got[r][c], c_exp[r][c]);
        chk({tag, "_wr_cnt"}, wr_cnt, 16);
    endtask

    // Memory model and output monitors, sampled mid-cycle.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (matrix_a_re && matrix_b_re) begin
                data_in_a = a_m[row_addr_a][col_addr_a];
                data_in_b = b_m[row_addr_b][col_addr_b];
                pq.push_back(64'(a_m[row_addr_a][col_addr_a] * b_m[row_addr_b][col_addr_b]));
            end
            if (paused && (matrix_a_re || matrix_b_re)) re_paused++;
            if (mult_done_reg) begin
                if (pq.size() == 0) begin
                    chk("prod_unexpected", 72'd1, 72'd0);
                end else begin
                    e = pq.pop_front();
                    chk("product", product_reg, e);
                    if (!first_seen) begin
                        first_seen = 1'b1;
                        chk("first_prod", product_reg, 72'd6);
                    end
                end
            end
            if (matrix_c_we) begin
                chk("wr_order", {row_addr_c, col_addr_c}, wr_cnt[3:0]);
                c_got[row_addr_c][col_addr_c] = data_out_c;
                wr_cnt++;
            end
            if (s_we) begin
                chk("sgn_data", s_dout, 72'h3FFE8);
                s_wr++;
            end
            if (c_we) begin
                chk("max_data", c_dout, 72'd260100);
                c_wr++;
            end
        end
    end

    initial begin
        int cyc;
        int n;
        data_in_a = '0;
        data_in_b = '0;
        clear_run();

        tick();
        tick();
        chk("rst_done", {71'd0, mac_done}, 72'd0);
        chk("rst_acc", acc_reg, 72'd0);
        chk("rst_prod", product_reg, 72'd0);
        chk("rst_ctl", {matrix_a_re, matrix_b_re, matrix_c_we, mult_done_reg}, 72'd0);
        reset = 1'b0;
        tick();

        // plain run
        run_main(0, cyc);
        chk("cycles", cyc, 272);
        check_c("run1");

        // pause during the second READ of element (1,2): cycle 106 after first READ
        clear_run();
        re_paused = 0;
        run_main(107, cyc);
        chk("pause_cycles", cyc, 282);
        chk("re_while_paused", re_paused, 0);
        check_c("pause");

        // reset during ACC of element (2,1): cycle 156 after first READ
        clear_run();
        do_mac = 1'b1;
        repeat (157) tick();
        reset = 1'b1;
        do_mac = 1'b0;
        tick();
        reset = 1'b0;
        chk("mrst_acc", acc_reg, 72'd0);
        chk("mrst_prod", product_reg, 72'd0);
        chk("mrst_ctl", {matrix_a_re, matrix_c_we, mult_done_reg, mac_done}, 72'd0);
        chk("mrst_addr", {row_addr_a, col_addr_a, col_addr_b, row_addr_c, col_addr_c}, 72'd0);
        chk("mrst_dout", data_out_c, 72'd0);
        tick();
        clear_run();
        run_main(0, cyc);
        chk("fresh_cycles", cyc, 272);
        check_c("fresh");

        // signed and max-value 8-bit instances
        do_mac2 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(s_done && c_done) && n < 1000);
        chk("sgn_cycles", n - 1, 272);
        chk("sgn_wr_cnt", s_wr, 16);
        chk("max_wr_cnt", c_wr, 16);
        do_mac2 = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
